mc_ctrl: RTL and testbench

//  Multi-cycle main controller directly downstream of the ifu: latches the fetched inst into an

---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/mc_ctrl_dec.sv | 37 +++
 rtl/mc_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller.
// Opcodes, functs, state codes and datapath select codes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] IFU_SEL_NORM       = 2'd0;
  localparam logic [1:0] IFU_SEL_RELATIVE   = 2'd1;
  localparam logic [1:0] IFU_SEL_IRRELATIVE = 2'd2;
  localparam logic [1:0] IFU_SEL_REGISTER   = 2'd3;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HI   = 2'd2;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic jr;
  } cls_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Instruction decoder: opcode/funct -> one-hot class.
// Anything outside the supported subset flags illegal.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       illegal
);

  // one-hot class from opcode, funct only for R-type
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: ;
    endcase
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: IR latch + FETCH/DECODE/EXEC/MEM/WB.
// Optional perf counters when MC_CTRL_PERF_EN is defined.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic              zero,
  output logic [INST_W-1:0] ir,
  output logic              pc_we,
  output logic [1:0]        npc_sel,
  output logic              reg_we,
  output logic [1:0]        reg_dst,
  output logic [1:0]        wd_sel,
  output logic [1:0]        ext_op,
  output logic              alu_src_b,
  output logic [2:0]        alu_op,
  output logic              mem_we,
  output logic              illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt
`endif
);

  state_t state;
  state_t nxt;
  cls_t   cls;
  logic   bad;

  mc_ctrl_dec u_dec (
    .op      (ir[31:26]),
    .funct   (ir[5:0]),
    .cls     (cls),
    .illegal (bad)
  );

  // next-state selection; unused codes fall back to FETCH
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (cls.j || cls.jal || cls.jr || bad)
          nxt = S_FETCH;
        else
          nxt = S_EXEC;
      end
      S_EXEC: begin
        if (cls.lw || cls.sw)
          nxt = S_MEM;
        else if (cls.addu || cls.subu ||
                 cls.ori  || cls.lui)
          nxt = S_WB;
        else
          nxt = S_FETCH;
      end
      S_MEM:    nxt = cls.lw ? S_WB : S_FETCH;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // state register and IR latch (IR only loads in FETCH)
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (state == S_FETCH)
        ir <= inst;
    end
  end

  // datapath selects depend only on the IR so they hold EXEC..WB
  always_comb begin
    reg_dst   = RD_RT;
    wd_sel    = WD_ALU;
    ext_op    = EXT_ZERO;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    unique case (1'b1)
      cls.addu: reg_dst = RD_RD;
      cls.subu: begin
        reg_dst = RD_RD;
        alu_op  = ALU_SUB;
      end
      cls.ori: begin
        alu_src_b = 1'b1;
        alu_op    = ALU_OR;
      end
      cls.lui: begin
        ext_op    = EXT_HI;
        alu_src_b = 1'b1;
        alu_op    = ALU_PASS;
      end
      cls.lw: begin
        wd_sel    = WD_MEM;
        ext_op    = EXT_SIGN;
        alu_src_b = 1'b1;
      end
      cls.sw: begin
        ext_op    = EXT_SIGN;
        alu_src_b = 1'b1;
      end
      cls.beq: alu_op = ALU_SUB;
      cls.jal: begin
        reg_dst = RD_RA;
        wd_sel  = WD_PC;
      end
      default: ;
    endcase
  end

  // enables from state + class; all forced low while reset is high
  always_comb begin
    pc_we   = 1'b0;
    npc_sel = IFU_SEL_NORM;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    illegal = 1'b0;
    case (state)
      S_FETCH: pc_we = 1'b1;
      S_DECODE: begin
        if (cls.j) begin
          pc_we   = 1'b1;
          npc_sel = IFU_SEL_IRRELATIVE;
        end else if (cls.jal) begin
          pc_we   = 1'b1;
          npc_sel = IFU_SEL_IRRELATIVE;
          reg_we  = 1'b1;
        end else if (cls.jr) begin
          pc_we   = 1'b1;
          npc_sel = IFU_SEL_REGISTER;
        end else if (bad) begin
          illegal = 1'b1;
        end
      end
      S_EXEC: begin
        if (cls.beq) begin
          pc_we   = zero;
          npc_sel = IFU_SEL_RELATIVE;
        end
      end
      S_MEM:   mem_we = cls.sw;
      S_WB:    reg_we = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_we   = 1'b0;
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      illegal = 1'b0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic retire;

  assign retire = (state != S_FETCH) && (nxt == S_FETCH) &&
                  !((state == S_DECODE) && bad);

  // free-running cycle count and retired-instruction count
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)
        inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: one task per scenario.
// Define MC_CTRL_PERF_EN to also check the counters.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        zero;
  logic [31:0] ir;
  logic        pc_we;
  logic [1:0]  npc_sel;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic [1:0]  ext_op;
  logic        alu_src_b;
  logic [2:0]  alu_op;
  logic        mem_we;
  logic        illegal;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  // {pc_we, npc_sel, reg_we, mem_we, illegal}
  logic [5:0] en;
  assign en = {pc_we, npc_sel, reg_we, mem_we, illegal};

  localparam logic [5:0] EN_0   = 6'b0_00_000;
  localparam logic [5:0] EN_F   = 6'b1_00_000;
  localparam logic [5:0] EN_WB  = 6'b0_00_100;
  localparam logic [5:0] EN_SW  = 6'b0_00_010;
  localparam logic [5:0] EN_BT  = 6'b1_01_000;
  localparam logic [5:0] EN_BN  = 6'b0_01_000;
  localparam logic [5:0] EN_JAL = 6'b1_10_100;
  localparam logic [5:0] EN_JR  = 6'b1_11_000;
  localparam logic [5:0] EN_ILL = 6'b0_00_001;

  mc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .inst      (inst),
    .zero      (zero),
    .ir        (ir),
    .pc_we     (pc_we),
    .npc_sel   (npc_sel),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .ext_op    (ext_op),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .mem_we    (mem_we),
    .illegal   (illegal)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt (cycle_cnt),
    .inst_cnt  (inst_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    inst  = 32'h34010005;
    zero  = 1'b0;
    tick();
    tick();
    vecs++;
    if (en !== EN_0) begin
      errs++;
      $display("FAIL rst_en: got %b want %b", en, EN_0);
    end
    vecs++;
    if (ir !== 32'h0) begin
      errs++;
      $display("FAIL rst_ir: got %h want %h", ir, 32'h0);
    end
    reset = 1'b0;
    #1;
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL rst_fetch: got %b want %b", en, EN_F);
    end
  endtask

  task automatic test_ori;
    tick();
    vecs++;
    if (ir !== 32'h34010005 || en !== EN_0) begin
      errs++;
      $display("FAIL ori_dec: ir=%h en=%b want 34010005 %b",
               ir, en, EN_0);
    end
    tick();
    vecs++;
    if ({ext_op, alu_op, alu_src_b, en} !== {2'd0, 3'd2, 1'b1, EN_0}) begin
      errs++;
      $display("FAIL ori_exec: ext=%0d alu=%0d srcb=%b en=%b want 0 2 1 %b",
               ext_op, alu_op, alu_src_b, en, EN_0);
    end
    tick();
    vecs++;
    if ({en, reg_dst, wd_sel, alu_op} !== {EN_WB, 2'd0, 2'd0, 3'd2}) begin
      errs++;
      $display("FAIL ori_wb: en=%b dst=%0d wd=%0d alu=%0d want %b 0 0 2",
               en, reg_dst, wd_sel, alu_op, EN_WB);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL ori_cpi4: got %b want %b", en, EN_F);
    end
  endtask

  task automatic test_lw_sw;
    inst = 32'h8c220004;
    tick();
    tick();
    vecs++;
    if ({ext_op, alu_op, en} !== {2'd1, 3'd0, EN_0}) begin
      errs++;
      $display("FAIL lw_exec: ext=%0d alu=%0d en=%b want 1 0 %b",
               ext_op, alu_op, en, EN_0);
    end
    tick();
    vecs++;
    if (en !== EN_0) begin
      errs++;
      $display("FAIL lw_mem: got %b want %b", en, EN_0);
    end
    tick();
    vecs++;
    if ({en, wd_sel, reg_dst} !== {EN_WB, 2'd1, 2'd0}) begin
      errs++;
      $display("FAIL lw_wb: en=%b wd=%0d dst=%0d want %b 1 0",
               en, wd_sel, reg_dst, EN_WB);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL lw_cpi5: got %b want %b", en, EN_F);
    end
    inst = 32'hac220004;
    tick();
    tick();
    tick();
    vecs++;
    if (en !== EN_SW) begin
      errs++;
      $display("FAIL sw_mem: got %b want %b", en, EN_SW);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL sw_cpi4: got %b want %b", en, EN_F);
    end
  endtask

  task automatic test_beq;
    inst = 32'h10220003;
    zero = 1'b1;
    tick();
    tick();
    vecs++;
    if ({en, alu_op} !== {EN_BT, 3'd1}) begin
      errs++;
      $display("FAIL beq_taken: en=%b alu=%0d want %b 1", en, alu_op, EN_BT);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL beq_t_ret: got %b want %b", en, EN_F);
    end
    zero = 1'b0;
    tick();
    tick();
    vecs++;
    if (en !== EN_BN) begin
      errs++;
      $display("FAIL beq_not: got %b want %b", en, EN_BN);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL beq_n_ret: got %b want %b", en, EN_F);
    end
  endtask

  task automatic test_jump;
    inst = 32'h0c000c02;
    tick();
    vecs++;
    if ({en, reg_dst, wd_sel} !== {EN_JAL, 2'd2, 2'd2}) begin
      errs++;
      $display("FAIL jal_dec: en=%b dst=%0d wd=%0d want %b 2 2",
               en, reg_dst, wd_sel, EN_JAL);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL jal_ret: got %b want %b", en, EN_F);
    end
    inst = 32'h03e00008;
    tick();
    vecs++;
    if (en !== EN_JR) begin
      errs++;
      $display("FAIL jr_dec: got %b want %b", en, EN_JR);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL jr_ret: got %b want %b", en, EN_F);
    end
  endtask

  task automatic test_reset_mid;
    inst = 32'hac220004;
    tick();
    tick();
    tick();
    vecs++;
    if (en !== EN_SW) begin
      errs++;
      $display("FAIL mid_pre: got %b want %b", en, EN_SW);
    end
    reset = 1'b1;
    #1;
    vecs++;
    if (en !== EN_0) begin
      errs++;
      $display("FAIL mid_mask: got %b want %b", en, EN_0);
    end
    tick();
    vecs++;
    if (ir !== 32'h0 || en !== EN_0) begin
      errs++;
      $display("FAIL mid_ir: ir=%h en=%b want 00000000 %b", ir, en, EN_0);
    end
    reset = 1'b0;
    #1;
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL mid_fetch: got %b want %b", en, EN_F);
    end
  endtask

  task automatic test_illegal;
    reset = 1'b1;
    inst  = 32'h34010005;
    tick();
    tick();
    reset = 1'b0;
    #1;
    tick();
    tick();
    tick();
    tick();
    inst = 32'hfc000000;
    tick();
    vecs++;
    if (en !== EN_ILL) begin
      errs++;
      $display("FAIL ill_pulse: got %b want %b", en, EN_ILL);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL ill_ret: got %b want %b", en, EN_F);
    end
`ifdef MC_CTRL_PERF_EN
    vecs++;
    if (inst_cnt !== 32'd1 || cycle_cnt !== 32'd6) begin
      errs++;
      $display("FAIL perf: inst_cnt=%0d cycle_cnt=%0d want 1 6",
               inst_cnt, cycle_cnt);
    end
`endif
    inst = 32'h00000000;
    tick();
    vecs++;
    if (en !== EN_ILL) begin
      errs++;
      $display("FAIL ill_zero: got %b want %b", en, EN_ILL);
    end
    tick();
    inst = 32'h00221820;
    tick();
    vecs++;
    if (en !== EN_ILL) begin
      errs++;
      $display("FAIL ill_funct: got %b want %b", en, EN_ILL);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL ill_funct_ret: got %b want %b", en, EN_F);
    end
  endtask

  task automatic test_subu;
    inst = 32'h00221823;
    tick();
    tick();
    vecs++;
    if ({alu_op, alu_src_b} !== {3'd1, 1'b0}) begin
      errs++;
      $display("FAIL subu_exec: alu=%0d srcb=%b want 1 0", alu_op, alu_src_b);
    end
    tick();
    vecs++;
    if ({en, reg_dst} !== {EN_WB, 2'd1}) begin
      errs++;
      $display("FAIL subu_wb: en=%b dst=%0d want %b 1", en, reg_dst, EN_WB);
    end
    tick();
    vecs++;
    if (en !== EN_F) begin
      errs++;
      $display("FAIL subu_ret: got %b want %b", en, EN_F);
    end
  endtask

  initial begin
    test_reset();
    test_ori();
    test_lw_sw();
    test_beq();
    test_jump();
    test_subu();
    test_reset_mid();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
